// File: rtl/hazard_fwd_unit.sv
// Load-use stall and EX operand forwarding selects for a 5-stage MIPS pipeline.
// Optional macro HAZ_STALL_CNT_EN adds a 32-bit stall event counter output.
module hazard_fwd_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  dst_reg,
  input  logic        dst_we,
  input  logic        dst_is_load,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  // The WB slot is not stored: a WB match never forwards or stalls because
  // the register file writes in the first half-cycle.
  logic       ex_v_q,   ex_v_d;
  logic [4:0] ex_reg_q, ex_reg_d;
  logic       ex_ld_q,  ex_ld_d;
  logic       mem_v_q,  mem_v_d;
  logic [4:0] mem_reg_q, mem_reg_d;
  logic [1:0] fwd_a_q,  fwd_a_d;
  logic [1:0] fwd_b_q,  fwd_b_d;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic issue_v;

  function automatic logic src_hit(input logic use_s, input logic [4:0] s,
                                   input logic v, input logic [4:0] r);
    return use_s && (s != 5'd0) && v && (r == s);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic ex_ld,
                                         input logic hit_mem);
    if (hit_ex && !ex_ld) return 2'b01;
    else if (hit_mem)     return 2'b10;
    else                  return 2'b00;
  endfunction

  assign rs_ex  = src_hit(id_uses_rs, id_rs, ex_v_q,  ex_reg_q);
  assign rt_ex  = src_hit(id_uses_rt, id_rt, ex_v_q,  ex_reg_q);
  assign rs_mem = src_hit(id_uses_rs, id_rs, mem_v_q, mem_reg_q);
  assign rt_mem = src_hit(id_uses_rt, id_rt, mem_v_q, mem_reg_q);

  // Flush wins over stall: the squashed instruction must not hold the front end.
  assign stall   = !flush && ex_ld_q && (rs_ex || rt_ex);
  assign issue_v = dst_we && (dst_reg != 5'd0) && !stall && !flush;

  always_comb begin
    ex_v_d    = issue_v;
    ex_reg_d  = dst_reg;
    ex_ld_d   = issue_v && dst_is_load;
    mem_v_d   = ex_v_q;
    mem_reg_d = ex_reg_q;
    fwd_a_d   = 2'b00;
    fwd_b_d   = 2'b00;
    // A bubble enters EX on stall or flush, and a bubble must not forward.
    if (!stall && !flush) begin
      fwd_a_d = fwd_sel(rs_ex, ex_ld_q, rs_mem);
      fwd_b_d = fwd_sel(rt_ex, ex_ld_q, rt_mem);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v_q    <= 1'b0;
      ex_reg_q  <= 5'd0;
      ex_ld_q   <= 1'b0;
      mem_v_q   <= 1'b0;
      mem_reg_q <= 5'd0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
    end else begin
      ex_v_q    <= ex_v_d;
      ex_reg_q  <= ex_reg_d;
      ex_ld_q   <= ex_ld_d;
      mem_v_q   <= mem_v_d;
      mem_reg_q <= mem_reg_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)      stall_cnt_q <= 32'd0;
    else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Randomized + directed bench for hazard_fwd_unit with a queue-based scoreboard.
// Define HAZ_STALL_CNT_EN to also check the stall counter.
module tb_hazard_fwd_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt, dst_reg;
  logic        id_uses_rs, id_uses_rt, dst_we, dst_is_load, flush;
  logic        stall;
  logic [1:0]  fwd_a, fwd_b;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_fwd_unit dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .dst_reg     (dst_reg),
    .dst_we      (dst_we),
    .dst_is_load (dst_is_load),
    .flush       (flush),
    .stall       (stall),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
`ifdef HAZ_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {stall, fwd_a, fwd_b} expected for each cycle, plus counter.
  logic [4:0]  exp_q[$];
  logic [31:0] cnt_q[$];

  // Reference model: ordered history of in-flight writers, index 0 = youngest
  // (now in EX), index 1 = one older (MEM). Bubbles occupy a position too.
  typedef struct packed {
    logic       v;
    logic [4:0] r;
    logic       ld;
  } ent_t;

  ent_t        hist_m[2];
  logic [1:0]  fa_m, fb_m;
  logic [31:0] cnt_m;

  function automatic logic writes(input ent_t e, input logic use_s, input logic [4:0] s);
    return use_s && s != 0 && e.v && e.r == s;
  endfunction

  // Youngest producer wins; a load one ahead cannot forward yet (it stalls).
  function automatic logic [1:0] model_fwd(input logic use_s, input logic [4:0] s);
    for (int age = 0; age < 2; age++) begin
      if (writes(hist_m[age], use_s, s)) begin
        if (age == 0 && !hist_m[age].ld) return 2'b01;
        if (age == 1)                    return 2'b10;
      end
    end
    return 2'b00;
  endfunction

  task automatic model_reset();
    hist_m[0] = '0;
    hist_m[1] = '0;
    fa_m = 2'b00;
    fb_m = 2'b00;
    cnt_m = 32'd0;
  endtask

  // Driver: apply one ID-stage cycle, push expectations, advance the model.
  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] dst,
                      input logic we, input logic ld, input logic fl);
    logic       exp_stall;
    logic [1:0] nfa, nfb;
    ent_t       ne;
    @(posedge clk);
    #1;
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    dst_reg = dst; dst_we = we; dst_is_load = ld; flush = fl;

    exp_stall = !fl && hist_m[0].ld &&
                (writes(hist_m[0], urs, rs) || writes(hist_m[0], urt, rt));
    exp_q.push_back({exp_stall, fa_m, fb_m});
    cnt_q.push_back(cnt_m);

    if (rst) begin
      model_reset();
    end else begin
      nfa = model_fwd(urs, rs);
      nfb = model_fwd(urt, rt);
      fa_m = (exp_stall || fl) ? 2'b00 : nfa;
      fb_m = (exp_stall || fl) ? 2'b00 : nfb;
      if (exp_stall) cnt_m = cnt_m + 32'd1;
      ne.v  = we && dst != 0 && !exp_stall && !fl;
      ne.r  = dst;
      ne.ld = ld;
      hist_m[1] = hist_m[0];
      hist_m[0] = ne;
    end
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  initial begin
    logic [4:0]  e;
    logic [31:0] ec;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        ec = cnt_q.pop_front();
        n_checks++;
        if (stall !== e[4]) begin
          n_fail++;
          $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, e[4]);
        end
        n_checks++;
        if (fwd_a !== e[3:2]) begin
          n_fail++;
          $display("FAIL fwd_a t=%0t got=%b exp=%b", $time, fwd_a, e[3:2]);
        end
        n_checks++;
        if (fwd_b !== e[1:0]) begin
          n_fail++;
          $display("FAIL fwd_b t=%0t got=%b exp=%b", $time, fwd_b, e[1:0]);
        end
`ifdef HAZ_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== ec) begin
          n_fail++;
          $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, ec);
        end
`endif
      end
    end
  end

  initial begin
    reset = 1'b1; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    dst_reg = 0; dst_we = 0; dst_is_load = 0; flush = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // add $3 then sub reading rs=$3
    nop();
    step(0, 1, 2, 1, 1, 3, 1, 0, 0);
    step(0, 3, 4, 1, 1, 6, 1, 0, 0);
    nop(); nop();

    // lw $5 then add using rt=$5 (held through the stall)
    step(0, 1, 0, 1, 0, 5, 1, 1, 0);
    step(0, 2, 5, 1, 1, 6, 1, 0, 0);
    step(0, 2, 5, 1, 1, 6, 1, 0, 0);
    nop(); nop();

    // $7 writer, $8 writer, reader of $7 and $8
    step(0, 1, 2, 1, 1, 7, 1, 0, 0);
    step(0, 1, 2, 1, 1, 8, 1, 0, 0);
    step(0, 7, 8, 1, 1, 9, 1, 0, 0);
    nop(); nop();

    // writer and reader on $0
    step(0, 1, 0, 1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0, 1, 0, 0);
    nop(); nop();

    // lw $9, flushed dependent, then dependent sees MEM
    step(0, 1, 0, 1, 0, 9, 1, 1, 0);
    step(0, 9, 0, 1, 0, 10, 1, 0, 1);
    step(0, 9, 9, 1, 1, 11, 1, 0, 0);
    nop(); nop();

    // lw $4, reset, reader of $4
    step(0, 1, 0, 1, 0, 4, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 4, 4, 1, 1, 12, 1, 0, 0);
    nop(); nop();

    // back-to-back dependent loads
    step(0, 1, 0, 1, 0, 6, 1, 1, 0);
    step(0, 6, 0, 1, 0, 7, 1, 1, 0);
    step(0, 6, 0, 1, 0, 7, 1, 1, 0);
    step(0, 7, 0, 1, 0, 8, 1, 0, 0);
    step(0, 7, 0, 1, 0, 8, 1, 0, 0);
    nop(); nop();

    // Random traffic on a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end
    nop();

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
